// File: rtl/dpram_pkg.sv
// Shared constants for the 16x8 dual-port RAM and the FIFO controller in front of it.
package dpram_pkg;

  localparam int unsigned DPRAM_DW           = 8;
  localparam int unsigned DPRAM_AW           = 4;
  localparam int unsigned DPRAM_DEPTH        = 1 << DPRAM_AW;
  localparam int unsigned DPRAM_PTR_W        = DPRAM_AW;
  localparam int unsigned DPRAM_CNT_W        = DPRAM_AW + 1;
  localparam int unsigned DPRAM_AFULL_THRESH = 12;

  typedef logic [DPRAM_PTR_W-1:0] dpram_ptr_t;
  typedef logic [DPRAM_CNT_W-1:0] dpram_cnt_t;

endpackage

// File: rtl/dpram_fifo_ctrl.sv
// Synchronous FIFO controller driving dual_port_ram (port A write, port B look-ahead read).
// Optional fill_level/almost_full outputs enabled by defining DPRAM_FIFO_LEVEL_EN.
module dpram_fifo_ctrl
  import dpram_pkg::*;
#(
  parameter int unsigned DW           = DPRAM_DW,
  parameter int unsigned AW           = DPRAM_AW,
  parameter int unsigned AFULL_THRESH = DPRAM_AFULL_THRESH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          ram_we_a,
  output logic [AW-1:0] ram_addr_a,
  output logic [DW-1:0] ram_din_a,
  output logic          ram_we_b,
  output logic [AW-1:0] ram_addr_b,
  output logic [DW-1:0] ram_din_b,
  input  logic [DW-1:0] ram_dout_b
`ifdef DPRAM_FIFO_LEVEL_EN
  ,
  output logic [AW:0]   fill_level,
  output logic          almost_full
`endif
);

  localparam int unsigned   DEPTH     = 1 << AW;
  localparam logic [AW:0]   DEPTH_CNT = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   CNT_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};

  if (AFULL_THRESH > DEPTH) begin : g_thresh_chk
    $error("AFULL_THRESH exceeds FIFO depth");
  end

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          rd_valid_q, rd_valid_d;
  logic          push, pop;

  assign wr_ready = (count_q != DEPTH_CNT) & ~rst;
  assign push     = wr_valid & wr_ready;
  assign pop      = rd_valid_q & rd_ready;

  assign ram_we_a   = push & ~flush;
  assign ram_addr_a = wr_ptr_q;
  assign ram_din_a  = wr_data;
  assign ram_we_b   = 1'b0;
  assign ram_din_b  = '0;
  // Look ahead one slot on pop so the next head is already registered in the RAM.
  assign ram_addr_b = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
  assign rd_data    = ram_dout_b;
  assign rd_valid   = rd_valid_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_valid_d = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop)      count_d = count_q + CNT_ONE;
      else if (pop && !push) count_d = count_q - CNT_ONE;
      // Only entries committed before this cycle may become visible, which hides
      // the same-cycle read-during-write hazard on the RAM.
      rd_valid_d = pop ? (count_q != CNT_ONE) : (count_q != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
    end
  end

`ifdef DPRAM_FIFO_LEVEL_EN
  logic almost_full_q, almost_full_d;

  assign almost_full_d = int'(count_d) >= int'(AFULL_THRESH);
  assign fill_level    = count_q;
  assign almost_full   = almost_full_q;

  always_ff @(posedge clk) begin
    if (rst) almost_full_q <= 1'b0;
    else     almost_full_q <= almost_full_d;
  end
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Scoreboard bench for dpram_fifo_ctrl with a behavioural 16x8 RAM on its ports.
module tb_dpram_fifo_ctrl;

  localparam int DEPTH = 16;
  localparam int THR   = 12;

  logic       clk = 1'b0;
  logic       rst, flush, wr_valid, wr_ready, rd_valid, rd_ready;
  logic [7:0] wr_data, rd_data, ram_din_a, ram_din_b, ram_dout_b;
  logic       ram_we_a, ram_we_b;
  logic [3:0] ram_addr_a, ram_addr_b;
`ifdef DPRAM_FIFO_LEVEL_EN
  logic [4:0] fill_level;
  logic       almost_full;
`endif

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bit         streaming = 1'b0;
  logic [7:0] exp_q[$];
  int         stamp_q[$];
  bit         mon_vis, mon_we;
  logic [7:0] mem [16];

  dpram_fifo_ctrl #(.DW(8), .AW(4), .AFULL_THRESH(THR)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a), .ram_din_a(ram_din_a),
    .ram_we_b(ram_we_b), .ram_addr_b(ram_addr_b), .ram_din_b(ram_din_b),
    .ram_dout_b(ram_dout_b)
`ifdef DPRAM_FIFO_LEVEL_EN
    , .fill_level(fill_level), .almost_full(almost_full)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM: registered read, same-address read during write returns old data.
  initial for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
    ram_dout_b <= mem[ram_addr_b];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: FIFO of words; the head becomes visible two cycles after it was written.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_wr_ready", 32'(wr_ready), 0);
      chk("rst_we_a", 32'(ram_we_a), 0);
      exp_q.delete();
      stamp_q.delete();
    end else begin
      mon_vis = (exp_q.size() != 0) && (stamp_q[0] <= cyc - 2);
      chk("rd_valid", 32'(rd_valid), 32'(mon_vis));
      chk("wr_ready", 32'(wr_ready), 32'(exp_q.size() != DEPTH));
      mon_we = wr_valid && (exp_q.size() != DEPTH) && !flush;
      chk("ram_we_a", 32'(ram_we_a), 32'(mon_we));
      if (mon_we) chk("ram_din_a", 32'(ram_din_a), 32'(wr_data));
      chk("ram_b_const", 32'({ram_we_b, ram_din_b}), 0);
`ifdef DPRAM_FIFO_LEVEL_EN
      chk("fill_level", 32'(fill_level), 32'(exp_q.size()));
      chk("almost_full", 32'(almost_full), 32'(exp_q.size() >= THR));
`endif
      if (streaming) chk("stream_occupancy_le2", 32'(exp_q.size() <= 2), 1);
      if (flush) begin
        exp_q.delete();
        stamp_q.delete();
      end else begin
        if (rd_valid && rd_ready && mon_vis) begin
          chk("rd_data", 32'(rd_data), 32'(exp_q[0]));
          void'(exp_q.pop_front());
          void'(stamp_q.pop_front());
        end
        if (mon_we) begin
          exp_q.push_back(wr_data);
          stamp_q.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int wp, rp;
    rst = 1'b1; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_addr_a", 32'(ram_addr_a), 0);
    chk("post_rst_addr_b", 32'(ram_addr_b), 0);
    chk("post_rst_rd_valid", 32'(rd_valid), 0);
    chk("post_rst_wr_ready", 32'(wr_ready), 1);
    repeat (2) tick();

    // Single word into empty FIFO: visible two cycles later, gone after the pop.
    wr_valid = 1'b1; wr_data = 8'hA5; rd_ready = 1'b1;
    tick();
    wr_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("a5_valid", 32'(rd_valid), 1);
    chk("a5_data", 32'(rd_data), 32'h A5);
    tick();
    @(negedge clk);
    chk("a5_after_pop", 32'(rd_valid), 0);
    tick();

    // Fill to full, attempt a 17th write, then drain at one word per cycle.
    rd_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1'b1; wr_data = 8'(i);
      tick();
    end
    wr_data = 8'hEE;
    @(negedge clk);
    chk("full_wr_ready", 32'(wr_ready), 0);
    tick();
    wr_valid = 1'b0; rd_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd_valid) n++;
      tick();
    end
    chk("drain_words", 32'(n), 16);

    // Continuous streaming through both pointer wraps.
    streaming = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wr_valid = 1'b1; wr_data = 8'(8'h80 + i); rd_ready = 1'b1;
      tick();
    end
    wr_valid = 1'b0;
    repeat (4) tick();
    streaming = 1'b0;
    @(negedge clk);
    chk("stream_drained", 32'(exp_q.size()), 0);
    tick();

    // Flush with three held entries, then no stale data afterwards.
    rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_data = 8'($urandom);
      tick();
    end
    wr_valid = 1'b0;
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_rd_valid", 32'(rd_valid), 0);
    chk("flush_wr_ready", 32'(wr_ready), 1);
    tick();
    wr_valid = 1'b1; wr_data = 8'h5A; rd_ready = 1'b1;
    tick();
    wr_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("flush_5a_valid", 32'(rd_valid), 1);
    chk("flush_5a_data", 32'(rd_data), 32'h5A);
    repeat (2) tick();

`ifdef DPRAM_FIFO_LEVEL_EN
    rd_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      wr_valid = 1'b1; wr_data = 8'($urandom);
      tick();
    end
    wr_valid = 1'b0;
    @(negedge clk);
    chk("lvl12_fill", 32'(fill_level), 12);
    chk("lvl12_afull", 32'(almost_full), 1);
    tick();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    @(negedge clk);
    chk("lvl11_fill", 32'(fill_level), 11);
    chk("lvl11_afull", 32'(almost_full), 0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
`endif

    // Randomized traffic with occasional flush and reset.
    wp = 50; rp = 50;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) begin
        wp = $urandom_range(10, 95);
        rp = $urandom_range(10, 95);
      end
      rst      = ($urandom_range(0, 299) == 0);
      flush    = ($urandom_range(0, 59) == 0);
      wr_valid = ($urandom_range(0, 99) < wp);
      rd_ready = ($urandom_range(0, 99) < rp);
      wr_data  = 8'($urandom);
      tick();
    end
    rst = 1'b0; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b1;
    repeat (24) tick();
    @(negedge clk);
    chk("final_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
